// File: rtl/pmp_fault_ctrl.sv
// Purpose : turns per-channel PMP pass/fail results into registered allow/fault
//           responses and a held trap request, with saturating fault/drop counters.
// Latency : responses and trap capture one cycle after the check; no backpressure,
//           accesses are blocked (no responses) from capture until a flush.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   v_req_vld/addr/mode       per-channel access presented to the PMP checker
//   v_pass                    per-channel PMP result (same cycle)
//   flush                     pipeline flush, kills checks and releases block
//   trap_ack                  trap unit accepted the pending trap request
//   v_acc_ok/v_acc_fault      registered per-channel responses
//   trap_req/cause/tval/chan  held trap request for the trap unit
//   fault_cnt/drop_cnt        saturating statistics counters
module pmp_fault_ctrl #(
    parameter int REQ_CHANNEL_NUM = 3,
    parameter int ADDR_WIDTH      = 32,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [REQ_CHANNEL_NUM-1:0]                  v_req_vld,
    input  logic [REQ_CHANNEL_NUM-1:0][ADDR_WIDTH-1:0]  v_req_addr,
    input  logic [REQ_CHANNEL_NUM-1:0][1:0]             v_req_mode,
    input  logic [REQ_CHANNEL_NUM-1:0]                  v_pass,
    input  logic                                        flush,
    input  logic                                        trap_ack,
    output logic [REQ_CHANNEL_NUM-1:0]                  v_acc_ok,
    output logic [REQ_CHANNEL_NUM-1:0]                  v_acc_fault,
    output logic                                        trap_req,
    output logic [3:0]                                  trap_cause,
    output logic [ADDR_WIDTH-1:0]                       trap_tval,
    output logic [$clog2(REQ_CHANNEL_NUM)-1:0]          trap_chan,
    output logic [CNT_WIDTH-1:0]                        fault_cnt,
    output logic [CNT_WIDTH-1:0]                        drop_cnt
);

    localparam int CW = $clog2(REQ_CHANNEL_NUM);
    localparam int PW = $clog2(REQ_CHANNEL_NUM + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRAP  = 2'd1,
        ST_BLOCK = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [REQ_CHANNEL_NUM-1:0] active;
    logic [REQ_CHANNEL_NUM-1:0] fail;
    logic [CW-1:0]              sel_idx;
    logic [1:0]                 sel_mode;
    logic [ADDR_WIDTH-1:0]      sel_addr;
    logic [PW-1:0]              fail_pop;
    logic                       resp_en;
    logic                       capture;
    logic [PW-1:0]              drop_add;
    logic [CNT_WIDTH:0]         fault_sum;
    logic [CNT_WIDTH:0]         drop_sum;
    logic [3:0]                 sel_cause;

    // Mode 00 is "no access" even when the valid bit is set.
    always_comb begin
        for (int i = 0; i < REQ_CHANNEL_NUM; i++) begin
            active[i] = v_req_vld[i] & (v_req_mode[i] != 2'b00);
        end
        fail = active & ~v_pass;
    end

    // Walk from the highest index down so the lowest failing channel wins.
    always_comb begin
        sel_idx  = '0;
        sel_mode = 2'b00;
        sel_addr = '0;
        fail_pop = '0;
        for (int i = REQ_CHANNEL_NUM - 1; i >= 0; i--) begin
            if (fail[i]) begin
                sel_idx  = CW'(i);
                sel_mode = v_req_mode[i];
                sel_addr = v_req_addr[i];
            end
        end
        for (int i = 0; i < REQ_CHANNEL_NUM; i++) begin
            fail_pop = fail_pop + PW'(fail[i]);
        end
    end

    always_comb begin
        case (sel_mode)
            2'b11:   sel_cause = 4'd1;
            2'b01:   sel_cause = 4'd5;
            2'b10:   sel_cause = 4'd7;
            default: sel_cause = 4'd0;
        endcase
    end

    assign resp_en = (state == ST_IDLE) & ~flush;
    assign capture = resp_en & (|fail);

    // Faults that are not captured: the losers of the capture cycle, and every
    // fault that arrives while blocked (unless a flush is killing them).
    always_comb begin
        drop_add = '0;
        if (capture) begin
            drop_add = fail_pop - PW'(1);
        end else if ((state != ST_IDLE) && !flush) begin
            drop_add = fail_pop;
        end
    end

    assign fault_sum = {1'b0, fault_cnt} + {{CNT_WIDTH{1'b0}}, 1'b1};
    assign drop_sum  = {1'b0, drop_cnt} + {{(CNT_WIDTH + 1 - PW){1'b0}}, drop_add};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (capture) begin
                    state_nxt = ST_TRAP;
                end
            end
            ST_TRAP: begin
                // Flush wins over ack: an acked trap released by a flush
                // needs no block.
                if (flush) begin
                    state_nxt = ST_IDLE;
                end else if (trap_ack) begin
                    state_nxt = ST_BLOCK;
                end
            end
            ST_BLOCK: begin
                if (flush) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Decoded straight from the state register so reset clears it at once.
    assign trap_req = (state == ST_TRAP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_acc_ok    <= '0;
            v_acc_fault <= '0;
            trap_cause  <= '0;
            trap_tval   <= '0;
            trap_chan   <= '0;
            fault_cnt   <= '0;
            drop_cnt    <= '0;
        end else begin
            if (resp_en) begin
                v_acc_ok    <= active & v_pass;
                v_acc_fault <= fail;
            end else begin
                v_acc_ok    <= '0;
                v_acc_fault <= '0;
            end
            if (capture) begin
                trap_cause <= sel_cause;
                trap_tval  <= sel_addr;
                trap_chan  <= sel_idx;
                fault_cnt  <= fault_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : fault_sum[CNT_WIDTH-1:0];
            end
            if (drop_add != '0) begin
                drop_cnt <= drop_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : drop_sum[CNT_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_pmp_fault_ctrl.sv
// Purpose : directed and random stimulus for pmp_fault_ctrl against a
//           transaction-level reference model.
// Timing  : inputs change on the falling edge, outputs checked on the next falling edge.
module tb_pmp_fault_ctrl;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int CW = 16;

    logic              clk;
    logic              rst;
    logic [N-1:0]      v_req_vld;
    logic [N-1:0][AW-1:0] v_req_addr;
    logic [N-1:0][1:0] v_req_mode;
    logic [N-1:0]      v_pass;
    logic              flush;
    logic              trap_ack;
    logic [N-1:0]      v_acc_ok;
    logic [N-1:0]      v_acc_fault;
    logic              trap_req;
    logic [3:0]        trap_cause;
    logic [AW-1:0]     trap_tval;
    logic [1:0]        trap_chan;
    logic [CW-1:0]     fault_cnt;
    logic [CW-1:0]     drop_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: "pending" = trap waiting for the trap unit,
    // "blocked" = trap taken, waiting for the flush.
    bit          m_pending;
    bit          m_blocked;
    logic [N-1:0] m_ok, m_fault;
    int          m_cause;
    logic [AW-1:0] m_tval;
    int          m_chan;
    int          m_fcnt, m_dcnt;

    pmp_fault_ctrl #(.REQ_CHANNEL_NUM(N), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .v_req_vld   (v_req_vld),
        .v_req_addr  (v_req_addr),
        .v_req_mode  (v_req_mode),
        .v_pass      (v_pass),
        .flush       (flush),
        .trap_ack    (trap_ack),
        .v_acc_ok    (v_acc_ok),
        .v_acc_fault (v_acc_fault),
        .trap_req    (trap_req),
        .trap_cause  (trap_cause),
        .trap_tval   (trap_tval),
        .trap_chan   (trap_chan),
        .fault_cnt   (fault_cnt),
        .drop_cnt    (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    function automatic int cause_of(input logic [1:0] m);
        if (m == 2'b11) return 1;
        if (m == 2'b01) return 5;
        if (m == 2'b10) return 7;
        return 0;
    endfunction

    task automatic model_reset();
        m_pending = 0; m_blocked = 0;
        m_ok = '0; m_fault = '0;
        m_cause = 0; m_tval = '0; m_chan = 0;
        m_fcnt = 0; m_dcnt = 0;
    endtask

    // Applies one clock of the rules to the model using the current inputs.
    task automatic model_step();
        int fails[$];
        bit idle;
        idle = !m_pending && !m_blocked;
        for (int i = 0; i < N; i++) begin
            if (v_req_vld[i] && v_req_mode[i] != 2'b00 && !v_pass[i]) fails.push_back(i);
        end
        m_ok = '0;
        m_fault = '0;
        if (idle && !flush) begin
            for (int i = 0; i < N; i++) begin
                if (v_req_vld[i] && v_req_mode[i] != 2'b00) begin
                    m_ok[i]    = v_pass[i];
                    m_fault[i] = !v_pass[i];
                end
            end
        end
        if (idle) begin
            if (!flush && fails.size() > 0) begin
                m_cause   = cause_of(v_req_mode[fails[0]]);
                m_tval    = v_req_addr[fails[0]];
                m_chan    = fails[0];
                m_pending = 1;
                m_fcnt    = sat(m_fcnt + 1);
                m_dcnt    = sat(m_dcnt + fails.size() - 1);
            end
        end else begin
            if (!flush) m_dcnt = sat(m_dcnt + fails.size());
            if (m_pending) begin
                if (flush) m_pending = 0;
                else if (trap_ack) begin m_pending = 0; m_blocked = 1; end
            end else if (flush) begin
                m_blocked = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ok"},    64'(v_acc_ok),    64'(m_ok));
        chk({tag, ".fault"}, 64'(v_acc_fault), 64'(m_fault));
        chk({tag, ".req"},   64'(trap_req),    64'(m_pending));
        chk({tag, ".cause"}, 64'(trap_cause),  64'(m_cause));
        chk({tag, ".tval"},  64'(trap_tval),   64'(m_tval));
        chk({tag, ".chan"},  64'(trap_chan),   64'(m_chan));
        chk({tag, ".fcnt"},  64'(fault_cnt),   64'(m_fcnt));
        chk({tag, ".dcnt"},  64'(drop_cnt),    64'(m_dcnt));
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic clear_in();
        v_req_vld = '0; v_req_mode = '0; v_pass = '1; v_req_addr = '0;
        flush = 1'b0; trap_ack = 1'b0;
    endtask

    task automatic set_ch(input int i, input logic [1:0] m, input logic [AW-1:0] a, input logic p);
        v_req_vld[i]  = 1'b1;
        v_req_mode[i] = m;
        v_req_addr[i] = a;
        v_pass[i]     = p;
    endtask

    initial begin
        int saved_f, saved_d;
        bit prev_flush;
        clear_in();
        model_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        // Passing load on ch1.
        set_ch(1, 2'b01, 32'h8000_0010, 1'b1);
        step("pass_load");
        chk("pass_load.ok_const", 64'(v_acc_ok), 64'h2);

        // Two faults in one cycle: ch0 store wins over ch2 fetch.
        clear_in();
        set_ch(2, 2'b11, 32'h0000_1000, 1'b0);
        set_ch(0, 2'b10, 32'h2000_0004, 1'b0);
        step("capture");
        chk("capture.cause_const", 64'(trap_cause), 64'd7);
        chk("capture.tval_const",  64'(trap_tval),  64'h2000_0004);
        chk("capture.fault_const", 64'(v_acc_fault), 64'h5);
        chk("capture.dcnt_const",  64'(drop_cnt),   64'd1);

        // Hold in TRAP with a passing load, then acknowledge.
        clear_in();
        set_ch(1, 2'b01, 32'h0000_0040, 1'b1);
        for (int k = 0; k < 3; k++) step("hold");
        chk("hold.req_const", 64'(trap_req), 64'd1);
        trap_ack = 1'b1;
        step("ack");
        chk("ack.req_const", 64'(trap_req), 64'd0);

        // BLOCK: failing load is dropped; then flush and a fresh fault.
        clear_in();
        set_ch(1, 2'b01, 32'h0000_0080, 1'b0);
        step("block_drop");
        chk("block_drop.dcnt_const", 64'(drop_cnt), 64'd2);
        clear_in();
        flush = 1'b1;
        step("block_flush");
        clear_in();
        step("post_flush_idle");
        set_ch(0, 2'b01, 32'h3000_0000, 1'b0);
        step("load_fault");
        chk("load_fault.cause_const", 64'(trap_cause), 64'd5);
        chk("load_fault.tval_const",  64'(trap_tval),  64'h3000_0000);

        // Flush aborts a pending trap without ack.
        clear_in();
        flush = 1'b1;
        step("trap_abort");
        chk("trap_abort.req_const", 64'(trap_req), 64'd0);
        clear_in();
        step("abort_idle");

        // Mode 00 with valid and fail is not an access.
        saved_f = m_fcnt; saved_d = m_dcnt;
        set_ch(0, 2'b00, 32'h4000_0000, 1'b0);
        step("mode00");
        chk("mode00.fcnt_same", 64'(fault_cnt), 64'(saved_f));
        chk("mode00.dcnt_same", 64'(drop_cnt),  64'(saved_d));

        // Saturation of fault_cnt.
        clear_in();
        force dut.fault_cnt = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.fault_cnt;
        m_fcnt = 65535;
        step("preload");
        set_ch(2, 2'b10, 32'h5000_0000, 1'b0);
        step("sat_fault");
        chk("sat_fault.fcnt_const", 64'(fault_cnt), 64'hFFFF);

        // Reset asserted in the middle of TRAP clears everything at once.
        clear_in();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst.req",  64'(trap_req),  64'd0);
        chk("async_rst.fcnt", 64'(fault_cnt), 64'd0);
        chk("async_rst.dcnt", 64'(drop_cnt),  64'd0);
        @(negedge clk);
        check_all("in_reset");
        rst = 1'b0;

        // Random traffic. The cycle right after a flush carries no failing
        // access so the return-to-IDLE cycle stays out of the comparison.
        prev_flush = 1'b0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                v_req_vld[i]  = 1'($urandom_range(0, 1));
                v_req_mode[i] = 2'($urandom_range(0, 3));
                v_req_addr[i] = $urandom;
                v_pass[i]     = prev_flush ? 1'b1 : ($urandom_range(0, 99) < 65);
            end
            flush    = ($urandom_range(0, 99) < 12);
            trap_ack = ($urandom_range(0, 99) < 30);
            prev_flush = flush;
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
